uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single board UART transmit line between two byte requesters: the CPU MMIO port and the debug/loader path. It arbitrates round-robin with packet locking and serializes each granted byte as an 8N1 frame on `uart_tx`. `WAIT` clocks per bit is used, matching the `mother_board` `WAIT` parameter. It sits between the requesters and the `uart_tx` board pin.

## Interface
- `WAIT`, 8: clock cycles per UART bit; legal range is 2 or more.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 2: byte request, one bit per requester (index 0 = CPU, 1 = debug).
- `req_data` in 16: bytes to send; requester i uses `req_data[8*i+7:8*i]`.
- `req_last` in 2: marks the last byte of a packet; 0 keeps the grant locked to this requester.
- `req_ready` out 2: byte accepted on a clock edge where `req_valid[i] & req_ready[i]`.
- `grant_id` out 1: requester owning the current or most recent frame.
- `busy` out 1: high while a frame is in flight (START/DATA/STOP).
- `uart_tx` out 1: serial output; idle high.

## Operation
- States:
  - IDLE: waits for a request.
  - START: drives the start bit, 0.
  - DATA: drives 8 bits, LSB first.
  - STOP: drives the stop bit, 1.
- Registers:
  - `wait_cnt`: counts 0..WAIT-1; width is `$clog2(WAIT)`.
  - `bit_cnt`: 3 bits.
  - `shift`: 8 bits.
  - `lock` and `owner`.
  - `rr_last`: the last granted requester.
- `req_ready` is combinational and is nonzero only in IDLE:
  - If `lock`=1, `req_ready[owner] = 1`; the other bit is 0, even if it is valid.
  - Else if exactly one `req_valid` is high, that requester is ready.
  - Else if both are high, the requester ≠ `rr_last` is ready.
  - Else `req_ready` = 0.
- Accept in IDLE (`valid & ready`):
  - Load `shift` with the byte and set `grant_id`/`owner`/`rr_last` to i.
  - Set `lock = ~req_last[i]`.
  - Go to START with `wait_cnt`=0.
- START: after WAIT cycles, go to DATA with `bit_cnt`=0.
- DATA: `uart_tx = shift[0]`. Every WAIT cycles, shift right and increment `bit_cnt`. After bit 7, go to STOP.
- STOP: `uart_tx`=1 for WAIT cycles, then go to IDLE.
- While locked, the owner may leave `req_valid` low; the arbiter waits in IDLE indefinitely and ignores the other requester.
- `lock` clears only on acceptance of a byte with `req_last`=1, or on reset.
- Request data is sampled only at acceptance. Changes to `req_data` mid-frame have no effect.

## Timing
- Reset values:
  - State IDLE, `uart_tx`=1, `busy`=0.
  - `grant_id`=0, `lock`=0, `owner`=0.
  - `rr_last`=1, so requester 0 wins the first tie.
  - `req_ready` follows the IDLE rules above.
- Acceptance at edge T:
  - `uart_tx`=0 (start bit) during cycles T+1 .. T+WAIT.
  - Data bit k during T+1+(k+1)·WAIT .. T+(k+2)·WAIT.
  - Stop bit during T+1+9·WAIT .. T+10·WAIT.
  - IDLE from cycle T+10·WAIT+1. The earliest next acceptance is at that cycle's edge, so the minimum start-to-start spacing is 10·WAIT+1 cycles.
- `busy` is high exactly during cycles T+1 .. T+10·WAIT.
- Reset mid-frame: on the cycle after the reset edge, `uart_tx`=1, `busy`=0 and `lock`=0. The partial frame is dropped and is not resent.
- Reset asserted together with `valid & ready`: reset wins and nothing is accepted.

## Test plan
- Single byte at WAIT=8:
  - Stimulus: req0 sends 0x0F with last=1; accepted at edge T.
  - Required: `uart_tx` low for 8 cycles, then 1,1,1,1,0,0,0,0 (8 cycles each), then high.
  - Required: `busy` falls after cycle T+80.
  - Required: `req_ready[0]` high again at T+81.
- Simultaneous first requests after reset:
  - Stimulus: req0=0xA5 and req1=0x3C, both valid with last=1.
  - Required: 0xA5 is sent first, with `grant_id`=0.
  - Required: 0x3C is accepted at the first IDLE edge after that frame, with `grant_id`=1.
- Round-robin fairness:
  - Stimulus: both requesters continuously valid with last=1 for 4 frames.
  - Required: grant order 0,1,0,1.
  - Required: start bits 81 cycles apart at WAIT=8.
- Packet lock:
  - Stimulus: req0 sends 0x01, 0x02, 0x03 with last=0,0,1, and deasserts valid for 20 idle cycles between 0x02 and 0x03; req1 is valid throughout.
  - Required: `uart_tx` carries 0x01, 0x02, 0x03 before req1's byte.
  - Required: `req_ready[1]` stays 0 until 0x03 is accepted.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle during data bit 3 of 0xFF.
  - Required: `uart_tx`=1 and `busy`=0 on the next cycle.
  - Required: a new req1 byte is then sent as a clean, complete frame.
- Minimum WAIT:
  - Stimulus: WAIT=2; send 0x80.
  - Required: the frame is 20 cycles long, and only data bit 7 is high, during frame cycles 17–18.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte request bundle between the two requesters (CPU, debug) and the UART
// transmit arbiter. Bit/byte lane i belongs to requester i.
interface uart_tx_arbiter_if;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART transmit pin between
// two byte requesters and serializes each granted byte as an 8N1 frame.
module uart_tx_arbiter #(
  parameter int WAIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   req,
  output logic               grant_id,
  output logic               busy,
  output logic               uart_tx
);

  localparam int CW = (WAIT > 2) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;

  logic [1:0]    ready_s;
  logic [1:0]    hs_s;
  logic          accept_s;
  logic          accept_id_s;
  logic          tick_s;

  // Grant selection: a locked packet owner excludes the other requester.
  always_comb begin
    ready_s = 2'b00;
    if (state_q == S_IDLE) begin
      if (lock_q) begin
        ready_s = owner_q ? 2'b10 : 2'b01;
      end else begin
        case (req.req_valid)
          2'b01:   ready_s = 2'b01;
          2'b10:   ready_s = 2'b10;
          2'b11:   ready_s = rr_last_q ? 2'b01 : 2'b10;
          default: ready_s = 2'b00;
        endcase
      end
    end else begin
      ready_s = 2'b00;
    end
  end

  assign req.req_ready = ready_s;
  assign hs_s          = req.req_valid & ready_s;
  assign accept_s      = |hs_s;
  assign accept_id_s   = hs_s[1];
  assign tick_s        = (wait_q == WAIT_LAST);

  // Frame sequencer next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d   = S_START;
          wait_d    = {CW{1'b0}};
          shift_d   = accept_id_s ? req.req_data[15:8] : req.req_data[7:0];
          owner_d   = accept_id_s;
          rr_last_d = accept_id_s;
          grant_d   = accept_id_s;
          lock_d    = ~(accept_id_s ? req.req_last[1] : req.req_last[0]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_d = S_DATA;
          wait_d  = {CW{1'b0}};
          bit_d   = 3'd0;
        end else begin
          wait_d = wait_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DATA: begin
        if (tick_s) begin
          wait_d = {CW{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          wait_d = wait_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_STOP: begin
        if (tick_s) begin
          state_d = S_IDLE;
          wait_d  = {CW{1'b0}};
        end else begin
          wait_d = wait_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = {CW{1'b0}};
      end
    endcase

    // Line level is registered from the next state so it lines up with it.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= {CW{1'b0}};
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      lock_q    <= 1'b0;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign uart_tx  = tx_q;

endmodule
